// File: rtl/scale_stream_sequencer.sv
// Frame sequencer ahead of the 1:2 downscaler: tags beats with (x,y), shadows frame size, flushes between frames.
// Optional `SCALE_SEQ_ERR_COUNT_EN adds a saturating error counter; otherwise err_count is tied to 0.
module scale_stream_sequencer #(
  parameter int LUMA_BITS        = 8,
  parameter int COORD_BITS       = 11,
  parameter int MAX_INPUT_WIDTH  = 1280,
  parameter int MAX_INPUT_HEIGHT = 720
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_BITS-1:0] cfg_width,
  input  logic [COORD_BITS-1:0] cfg_height,
  input  logic [LUMA_BITS-1:0]  in_pixel,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [LUMA_BITS-1:0]  out_pixel,
  output logic                  out_valid,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic [COORD_BITS-1:0] r_width,
  output logic                  scaler_flush,
  output logic                  frame_done,
  output logic                  err_sof,
  output logic                  err_orphan,
  output logic                  err_cfg,
  output logic [7:0]            err_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  localparam logic [COORD_BITS-1:0] MAX_W = COORD_BITS'(MAX_INPUT_WIDTH);
  localparam logic [COORD_BITS-1:0] MAX_H = COORD_BITS'(MAX_INPUT_HEIGHT);
  localparam logic [COORD_BITS-1:0] MIN_D = COORD_BITS'(2);
  localparam logic [COORD_BITS-1:0] ONE   = COORD_BITS'(1);

  logic [1:0]            state_q, state_d;
  logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_BITS-1:0] rw_q, rw_d, rh_q, rh_d;
  logic [LUMA_BITS-1:0]  opix_q, opix_d;
  logic [COORD_BITS-1:0] ox_q, ox_d, oy_q, oy_d;
  logic                  ovld_q, ovld_d;
  logic                  fdone_q, fdone_d;
  logic                  flush_q, flush_d;
  logic                  esof_q, esof_d;
  logic                  eorph_q, eorph_d;
  logic                  ecfg_q, ecfg_d;

  logic accept;
  logic cfg_ok;
  logic x_last;
  logic y_last;

  assign in_ready = (state_q != S_FLUSH);
  assign accept   = in_valid & in_ready;

  assign cfg_ok = (cfg_width  >= MIN_D) && (cfg_width  <= MAX_W) && !cfg_width[0] &&
                  (cfg_height >= MIN_D) && (cfg_height <= MAX_H) && !cfg_height[0];

  assign x_last = (x_q == rw_q - ONE);
  assign y_last = (y_q == rh_q - ONE);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rw_d    = rw_q;
    rh_d    = rh_q;
    opix_d  = opix_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ovld_d  = 1'b0;
    fdone_d = 1'b0;
    esof_d  = 1'b0;
    eorph_d = 1'b0;
    ecfg_d  = 1'b0;
    // Flush trails the FLUSH state by one cycle so it lands after the last pixel's out_valid.
    flush_d = (state_q == S_FLUSH);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_sof) begin
            if (cfg_ok) begin
              rw_d    = cfg_width;
              rh_d    = cfg_height;
              opix_d  = in_pixel;
              ovld_d  = 1'b1;
              ox_d    = '0;
              oy_d    = '0;
              x_d     = ONE;
              y_d     = '0;
              state_d = S_ACTIVE;
            end else begin
              ecfg_d = 1'b1;
            end
          end else begin
            eorph_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          if (in_sof) begin
            esof_d  = 1'b1;
            state_d = S_FLUSH;
          end else begin
            opix_d = in_pixel;
            ovld_d = 1'b1;
            ox_d   = x_q;
            oy_d   = y_q;
            if (x_last) begin
              x_d = '0;
              if (y_last) begin
                y_d     = '0;
                fdone_d = 1'b1;
                state_d = S_FLUSH;
              end else begin
                y_d = y_q + ONE;
              end
            end else begin
              x_d = x_q + ONE;
            end
          end
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rw_q    <= '0;
      rh_q    <= '0;
      opix_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ovld_q  <= 1'b0;
      fdone_q <= 1'b0;
      flush_q <= 1'b0;
      esof_q  <= 1'b0;
      eorph_q <= 1'b0;
      ecfg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rw_q    <= rw_d;
      rh_q    <= rh_d;
      opix_q  <= opix_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ovld_q  <= ovld_d;
      fdone_q <= fdone_d;
      flush_q <= flush_d;
      esof_q  <= esof_d;
      eorph_q <= eorph_d;
      ecfg_q  <= ecfg_d;
    end
  end

`ifdef SCALE_SEQ_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((esof_q | eorph_q | ecfg_q) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign out_pixel    = opix_q;
  assign out_valid    = ovld_q;
  assign out_x        = ox_q;
  assign out_y        = oy_q;
  assign r_width      = rw_q;
  assign scaler_flush = flush_q;
  assign frame_done   = fdone_q;
  assign err_sof      = esof_q;
  assign err_orphan   = eorph_q;
  assign err_cfg      = ecfg_q;

endmodule

// File: tb/tb_scale_stream_sequencer.sv
// Scoreboard bench for scale_stream_sequencer: a frame-level reference model queues expected events,
// a negedge monitor pops and compares them. Honours `SCALE_SEQ_ERR_COUNT_EN for the counter check.
module tb_scale_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] cfg_width, cfg_height;
  logic [7:0]  in_pixel;
  logic        in_valid, in_sof, in_ready;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic [10:0] out_x, out_y, r_width;
  logic        scaler_flush, frame_done, err_sof, err_orphan, err_cfg;
  logic [7:0]  err_count;

  scale_stream_sequencer dut (
    .clk(clk), .reset(reset), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .r_width(r_width), .scaler_flush(scaler_flush), .frame_done(frame_done),
    .err_sof(err_sof), .err_orphan(err_orphan), .err_cfg(err_cfg), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // kind: 0 pixel, 1 early sof, 2 orphan, 3 bad config
  typedef struct {
    int       kind;
    int       pix;
    int       x;
    int       y;
    bit       done;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;
  int  fw, fh, n, err_total;
  bit  in_frame, blocked, flush_due, armed;
  int  vld_cnt = 0;
  int  cyc_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input int w, input int h);
    return (w >= 2) && (w <= 1280) && (w % 2 == 0) && (h >= 2) && (h <= 720) && (h % 2 == 0);
  endfunction

  function automatic int exp_errcnt();
`ifdef SCALE_SEQ_ERR_COUNT_EN
    return (err_total > 255) ? 255 : err_total;
`else
    return 0;
`endif
  endfunction

  function automatic void push_err(input int kind);
    ev_t e;
    e.kind = kind; e.pix = 0; e.x = 0; e.y = 0; e.done = 1'b0;
    exp_q.push_back(e);
    err_total++;
  endfunction

  // Frame-level model: pixel n of a frame sits at (n mod width, n div width).
  function automatic void model_accept(input int p, input bit sof);
    ev_t e;
    if (!in_frame) begin
      if (!sof) push_err(2);
      else if (!legal(int'(cfg_width), int'(cfg_height))) push_err(3);
      else begin
        fw = int'(cfg_width); fh = int'(cfg_height); n = 0; in_frame = 1'b1;
        e.kind = 0; e.pix = p; e.x = 0; e.y = 0; e.done = 1'b0;
        exp_q.push_back(e);
        n = 1;
      end
    end else if (sof) begin
      push_err(1);
      in_frame = 1'b0;
      blocked  = 1'b1;
    end else begin
      e.kind = 0; e.pix = p; e.x = n % fw; e.y = n / fw; e.done = (n == fw * fh - 1);
      exp_q.push_back(e);
      n++;
      if (e.done) begin
        in_frame = 1'b0;
        blocked  = 1'b1;
      end
    end
  endfunction

  task automatic step_cycle(input bit valid, input int p, input bit sof, output bit acc);
    bit rdy;
    in_valid = valid; in_pixel = p[7:0]; in_sof = sof;
    rdy = in_ready;
    check("in_ready", rdy, !blocked);
    @(posedge clk); #1;
    blocked = 1'b0;
    acc = valid && rdy;
    if (acc) model_accept(p, sof);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic beat(input int p, input bit sof);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step_cycle(1'b1, p, sof, acc);
    check("beat_accepted", acc, 1);
    check("r_width", r_width, fw);
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++) step_cycle(1'b0, 0, 1'b0, acc);
  endtask

  task automatic frame(input int w, input int h, input int base);
    cfg_width = w[10:0]; cfg_height = h[10:0];
    beat(base, 1'b1);
    for (int i = 1; i < w * h; i++) beat(base + i, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; in_pixel = 8'hAA; in_sof = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_frame = 1'b0; blocked = 1'b0; fw = 0; fh = 0; n = 0; err_total = 0;
    exp_q.delete();
    flush_due = 1'b0;
    check("rst_ctrl", {out_valid, frame_done, scaler_flush, err_sof, err_orphan, err_cfg}, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_r_width", r_width, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      int  nh;
      int  k;
      ev_t e;
      cyc_cnt++;
      if (out_valid) vld_cnt++;
      check("scaler_flush", scaler_flush, flush_due);
      flush_due = 1'b0;
      check("frame_done_qual", frame_done & ~out_valid, 0);
      nh = int'(out_valid) + int'(err_sof) + int'(err_orphan) + int'(err_cfg);
      if (nh != 0) begin
        check("one_event", nh, 1);
        k = out_valid ? 0 : err_sof ? 1 : err_orphan ? 2 : 3;
        if (exp_q.size() == 0) begin
          check("queue_size", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", k, e.kind);
          if (e.kind == 0) begin
            check("pixel", out_pixel, e.pix);
            check("x", out_x, e.x);
            check("y", out_y, e.y);
            check("frame_done", frame_done, e.done);
          end
          if ((e.kind == 0 && e.done) || e.kind == 1) flush_due = 1'b1;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, c0, r;
    int ws[5];
    int hs[3];
    ws = '{2, 4, 6, 3, 8};
    hs = '{2, 4, 5};
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    cfg_width = 11'd4; cfg_height = 11'd2;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    armed = 1'b1;

    // contiguous 4x2 frame
    frame(4, 2, 1);
    idle(3);

    // same frame with a gap after every beat: half duty
    v0 = vld_cnt; c0 = cyc_cnt;
    beat(1, 1'b1); idle(1);
    for (int p = 2; p <= 8; p++) begin beat(p, 1'b0); idle(1); end
    check("duty_50", (vld_cnt - v0) * 2, cyc_cnt - c0);
    idle(2);

    // early SOF aborts, then a clean frame restarts at (0,0)
    beat(1, 1'b1);
    for (int p = 2; p <= 5; p++) beat(p, 1'b0);
    beat(9, 1'b1);
    idle(2);
    frame(4, 2, 11);
    idle(3);

    // orphans and an illegal config
    do_reset();
    for (int p = 0; p < 3; p++) beat(40 + p, 1'b0);
    cfg_width = 11'd3;
    beat(7, 1'b1);
    idle(3);
    check("err_count_4", err_count, exp_errcnt());
    cfg_width = 11'd4;

    // config change mid-frame has no effect until the next SOF
    beat(1, 1'b1);
    beat(2, 1'b0);
    cfg_width = 11'd6;
    for (int p = 3; p <= 8; p++) beat(p, 1'b0);
    idle(2);
    check("r_width_hold", r_width, 4);
    beat(50, 1'b1);
    check("r_width_new", r_width, 6);
    for (int i = 1; i < 12; i++) beat(50 + i, 1'b0);
    idle(3);
    cfg_width = 11'd4;

    // reset while beat 5 is offered
    beat(1, 1'b1);
    for (int p = 2; p <= 4; p++) beat(p, 1'b0);
    do_reset();
    idle(1);
    frame(4, 2, 21);
    idle(3);

    // randomized traffic
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if (r == 99) do_reset();
      else if (!in_frame && r < 60) beat($urandom_range(0, 255), 1'b1);
      else if (r < 4) beat($urandom_range(0, 255), 1'b1);
      else if (r < 14) idle($urandom_range(1, 3));
      else if (r < 20) begin
        cfg_width  = ws[$urandom_range(0, 4)];
        cfg_height = hs[$urandom_range(0, 2)];
      end else beat($urandom_range(0, 255), 1'b0);
    end
    idle(4);
    check("queue_empty", exp_q.size(), 0);
    check("err_count_final", err_count, exp_errcnt());

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
